// File: rtl/perf_pkg.sv
// perf_pkg: event index constants and read-index width helper for the perf counter bank.
package perf_pkg;
  localparam int EV_RETIRED    = 0;
  localparam int EV_STALL      = 1;
  localparam int EV_BUBBLE     = 2;
  localparam int EV_FORWARD    = 3;
  localparam int EV_RAW        = 4;
  localparam int EV_BRANCH     = 5;
  localparam int EV_BR_TAKEN   = 6;
  localparam int EV_BR_MISPRED = 7;

  function automatic int idx_w(input int num_events);
    return (num_events < 1) ? 1 : $clog2(num_events + 1);
  endfunction
endpackage

// File: rtl/perf_counter.sv
// perf_counter: single event counter with clear, wrap-or-saturate and sticky overflow.
module perf_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, wrap;

  always_comb begin
    wrap  = inc & (&cnt_q);
    cnt_d = clr ? '0 : !inc ? cnt_q : wrap ? (SATURATE ? cnt_q : '0) : cnt_q + CNT_W'(1);
    ovf_d = !clr & (ovf_q | wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: cycle counter plus NUM_EVENTS event counters, shadow snapshot bank and read port.
// Optional PERF_OVF_IRQ_EN adds a registered overflow interrupt output irq_o.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_W      = 32,
  parameter int SATURATE   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             perf_enable,
  input  logic [NUM_EVENTS-1:0]            event_i,
  input  logic                             clear_i,
  input  logic                             snap_i,
  input  logic                             rd_req,
  input  logic [idx_w(NUM_EVENTS)-1:0]     rd_idx,
  output logic                             rd_valid,
  output logic [CNT_W-1:0]                 rd_data,
  output logic [NUM_EVENTS:0]              ovf_o
`ifdef PERF_OVF_IRQ_EN
  ,
  output logic                             irq_o
`endif
);
  localparam int IDX_W = idx_w(NUM_EVENTS);
  localparam int N     = NUM_EVENTS + 1;

  logic [N-1:0]     inc;
  logic [CNT_W-1:0] live     [N];
  logic [CNT_W-1:0] shadow_q [N];
  logic [CNT_W-1:0] shadow_d [N];
  logic [CNT_W-1:0] rd_sel, rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Slot 0 counts cycles, so its strobe is tied high.
  assign inc = {event_i, 1'b1} & {N{perf_enable}};

  for (genvar i = 0; i < N; i++) begin : g_cnt
    perf_counter #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE != 0)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[i]),
      .clr  (clear_i),
      .cnt_o(live[i]),
      .ovf_o(ovf_o[i])
    );
  end

  // Reads see the shadow as it was before this edge, so a same-cycle snap is not visible.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N; i++) rd_sel = (rd_idx == IDX_W'(i)) ? shadow_q[i] : rd_sel;
    for (int i = 0; i < N; i++) shadow_d[i] = snap_i ? live[i] : shadow_q[i];
    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? rd_sel : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < N; i++) shadow_q[i] <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < N; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

`ifdef PERF_OVF_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = |ovf_o;
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end
  assign irq_o = irq_q;
`endif
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: table vectors plus corner sequences on a wrapping and a saturating 8-bit bank.
module tb_perf_counter_bank;
  logic       clk = 1'b0, rst = 1'b1, perf_enable = 1'b0, clear_i = 1'b0, snap_i = 1'b0, rd_req = 1'b0;
  logic [7:0] event_i = 8'h00;
  logic [3:0] rd_idx = 4'd0;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic [8:0] o0, o1;
`ifdef PERF_OVF_IRQ_EN
  logic       q0, q1;
`endif
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_EVENTS(8), .CNT_W(8), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .perf_enable(perf_enable), .event_i(event_i), .clear_i(clear_i),
    .snap_i(snap_i), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(v0), .rd_data(d0), .ovf_o(o0)
`ifdef PERF_OVF_IRQ_EN
    , .irq_o(q0)
`endif
  );

  perf_counter_bank #(.NUM_EVENTS(8), .CNT_W(8), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .perf_enable(perf_enable), .event_i(event_i), .clear_i(clear_i),
    .snap_i(snap_i), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(v1), .rd_data(d1), .ovf_o(o1)
`ifdef PERF_OVF_IRQ_EN
    , .irq_o(q1)
`endif
  );

  typedef struct {
    logic       en;
    logic [7:0] ev;
    logic       clr;
    logic       snap;
    logic       req;
    logic [3:0] idx;
    logic       exp_v;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [7:0] ev);
    perf_enable = 1'b1;
    event_i = ev;
    repeat (n) tick();
    perf_enable = 1'b0;
    event_i = 8'h00;
  endtask

  task automatic pulse_clear;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic pulse_snap;
    snap_i = 1'b1;
    tick();
    snap_i = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [7:0] e0, input logic [7:0] e1, input string nm);
    rd_req = 1'b1;
    rd_idx = idx;
    tick();
    rd_req = 1'b0;
    chk({nm, " valid0"}, 64'(v0), 64'd1);
    chk({nm, " data0"}, 64'(d0), 64'(e0));
    chk({nm, " valid1"}, 64'(v1), 64'd1);
    chk({nm, " data1"}, 64'(d1), 64'(e1));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 8'd0};
    tbl[1]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 8'd0};
    tbl[2]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 8'd0};
    tbl[3]  = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 8'd0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 8'd2};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 8'd2};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2,  1'b1, 8'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8,  1'b1, 8'd0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 8'd0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 8'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 8'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8,  1'b1, 8'd1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 8'd3};
    tbl[13] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 8'd0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd1,  1'b1, 8'd2};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 8'd0};

    repeat (2) tick();
    chk("reset valid0", 64'(v0), 64'd0);
    chk("reset data0", 64'(d0), 64'd0);
    chk("reset ovf0", 64'(o0), 64'd0);
    chk("reset valid1", 64'(v1), 64'd0);
    chk("reset ovf1", 64'(o1), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      perf_enable = tbl[i].en;
      event_i     = tbl[i].ev;
      clear_i     = tbl[i].clr;
      snap_i      = tbl[i].snap;
      rd_req      = tbl[i].req;
      rd_idx      = tbl[i].idx;
      tick();
      chk($sformatf("vec%0d valid0", i), 64'(v0), 64'(tbl[i].exp_v));
      chk($sformatf("vec%0d valid1", i), 64'(v1), 64'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        chk($sformatf("vec%0d data0", i), 64'(d0), 64'(tbl[i].exp_d));
        chk($sformatf("vec%0d data1", i), 64'(d1), 64'(tbl[i].exp_d));
      end
      chk($sformatf("vec%0d ovf0", i), 64'(o0), 64'd0);
      chk($sformatf("vec%0d ovf1", i), 64'(o1), 64'd0);
    end
    perf_enable = 1'b0; event_i = 8'h00; clear_i = 1'b0; snap_i = 1'b0; rd_req = 1'b0;

    pulse_clear();
    run(300, 8'h03);
    pulse_snap();
    chk("wrap ovf0", 64'(o0), 64'h007);
    chk("sat ovf1", 64'(o1), 64'h007);
`ifdef PERF_OVF_IRQ_EN
    chk("irq0 set", 64'(q0), 64'd1);
    chk("irq1 set", 64'(q1), 64'd1);
`endif
    rd(4'd2, 8'd44, 8'd255, "ev1 300");

    rd_req = 1'b1; rd_idx = 4'd0; tick();
    chk("b2b idx0 valid", 64'({v0, v1}), 64'b11);
    chk("b2b idx0 data", 64'({d0, d1}), {48'd0, 8'd44, 8'd255});
    rd_idx = 4'd1; tick();
    chk("b2b idx1 valid", 64'({v0, v1}), 64'b11);
    chk("b2b idx1 data", 64'({d0, d1}), {48'd0, 8'd44, 8'd255});
    rd_idx = 4'd9; tick();
    chk("b2b idx9 valid", 64'({v0, v1}), 64'b11);
    chk("b2b idx9 data", 64'({d0, d1}), 64'd0);
    rd_req = 1'b0; tick();
    chk("b2b idle valid", 64'({v0, v1}), 64'b00);

    rd_req = 1'b1; rd_idx = 4'd0; tick();
    chk("pre-rst valid", 64'(v0), 64'd1);
    rd_req = 1'b0; rst = 1'b1; tick();
    chk("rst valid", 64'({v0, v1}), 64'b00);
    chk("rst ovf0", 64'(o0), 64'd0);
    chk("rst ovf1", 64'(o1), 64'd0);
    chk("rst data", 64'({d0, d1}), 64'd0);
`ifdef PERF_OVF_IRQ_EN
    chk("rst irq", 64'({q0, q1}), 64'b00);
`endif
    rd_req = 1'b1; tick();
    rst = 1'b0; rd_req = 1'b0;
    chk("rst+req valid", 64'({v0, v1}), 64'b00);
    tick();
    chk("post-rst valid", 64'({v0, v1}), 64'b00);
    rd(4'd0, 8'd0, 8'd0, "post-rst shadow");

    run(5, 8'h01);
    perf_enable = 1'b1; event_i = 8'h01; clear_i = 1'b1; tick();
    perf_enable = 1'b0; event_i = 8'h00; clear_i = 1'b0;
    pulse_snap();
    rd(4'd1, 8'd0, 8'd0, "clear vs inc");

    pulse_clear();
    run(17, 8'h04);
    snap_i = 1'b1; clear_i = 1'b1; tick();
    snap_i = 1'b0; clear_i = 1'b0;
    rd(4'd3, 8'd17, 8'd17, "snap+clear");
    pulse_snap();
    rd(4'd3, 8'd0, 8'd0, "resnap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
